// File: rtl/counter_gating_pkg.sv
// Shared constants for the gated counter bank:
// count modes, directions and parameter limits.
package counter_gating_pkg;

    localparam int MAX_CH    = 16;
    localparam int MAX_WIDTH = 32;
    localparam int MIN_WIDTH = 2;

    localparam bit MODE_WRAP     = 1'b0;
    localparam bit MODE_SATURATE = 1'b1;

    localparam bit DIR_UP = 1'b1;
    localparam bit DIR_DN = 1'b0;

endpackage

// File: rtl/clk_gate_cell.sv
// Integrated clock gate: low-transparent enable latch
// followed by an AND, so gclk never glitches.
module clk_gate_cell (
    input  logic clk,
    input  logic en,
    input  logic scan_en,
    output logic gclk
);

    logic en_lat;

    // Capture the request only while clk is low
    always_latch begin
        if (!clk) en_lat <= en | scan_en;
    end

    assign gclk = clk & en_lat;

endmodule

// File: rtl/gated_counter_bank.sv
// Bank of independent up/down counters, each on
// its own gated clock, with load and terminal flags.
module gated_counter_bank
    import counter_gating_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int WIDTH    = 4,
    parameter int SATURATE = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    scan_en,
    input  logic [NUM_CH-1:0]       enable,
    input  logic [NUM_CH-1:0]       up_dn,
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH*WIDTH-1:0] load_val,
    output logic [NUM_CH*WIDTH-1:0] count_out,
    output logic [NUM_CH-1:0]       tc_out,
    output logic [NUM_CH-1:0]       gclk_active
);

    localparam bit SAT_MODE =
        (SATURATE != 0) ? MODE_SATURATE : MODE_WRAP;
    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_MIN = '0;

    logic [NUM_CH-1:0] gclk;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch

        logic             req;
        logic             req_lat;
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] lv;
        logic             at_max;
        logic             at_min;

        assign req = enable[i] | load[i] | scan_en;
        assign lv  = load_val[i*WIDTH +: WIDTH];

        assign at_max = (cnt == CNT_MAX);
        assign at_min = (cnt == CNT_MIN);

        clk_gate_cell u_icg (
            .clk     (clk),
            .en      (enable[i] | load[i]),
            .scan_en (scan_en),
            .gclk    (gclk[i])
        );

        // Observable copy of the gate enable, same timing as the ICG latch
        always_latch begin
            if (!clk) req_lat <= req;
        end

        // Counter register on the channel's gated clock; load beats counting
        always_ff @(posedge gclk[i] or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
            end else if (load[i]) begin
                cnt <= lv;
            end else if (enable[i]) begin
                if (up_dn[i] == DIR_UP) begin
                    if (!(SAT_MODE == MODE_SATURATE && at_max))
                        cnt <= cnt + 1'b1;
                end else begin
                    if (!(SAT_MODE == MODE_SATURATE && at_min))
                        cnt <= cnt - 1'b1;
                end
            end
        end

        assign count_out[i*WIDTH +: WIDTH] = cnt;
        assign tc_out[i] = (up_dn[i] == DIR_UP) ? at_max : at_min;
        assign gclk_active[i] = req_lat;

    end

endmodule

// File: tb/tb_gated_counter_bank.sv
// Scoreboard bench for gated_counter_bank: a wrap and a
// saturate instance share stimulus; a monitor checks both.
module tb_gated_counter_bank;

  localparam int N = 4;
  localparam int W = 4;

  logic           clk      = 1'b0;
  logic           rst_n    = 1'b0;
  logic           scan_en  = 1'b0;
  logic [N-1:0]   enable   = '0;
  logic [N-1:0]   up_dn    = '0;
  logic [N-1:0]   load     = '0;
  logic [N*W-1:0] load_val = '0;

  logic [N*W-1:0] cw, cs;
  logic [N-1:0]   tw, ts, aw, as_s;

  gated_counter_bank #(
    .NUM_CH(N), .WIDTH(W), .SATURATE(0)
  ) dut_w (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en),
    .enable(enable), .up_dn(up_dn), .load(load),
    .load_val(load_val), .count_out(cw),
    .tc_out(tw), .gclk_active(aw)
  );

  gated_counter_bank #(
    .NUM_CH(N), .WIDTH(W), .SATURATE(1)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en),
    .enable(enable), .up_dn(up_dn), .load(load),
    .load_val(load_val), .count_out(cs),
    .tc_out(ts), .gclk_active(as_s)
  );

  always #5 clk = ~clk;

  logic [N-1:0] gw;
  logic [N-1:0] gprev = '0;
  int edges[N];
  assign gw = dut_w.gclk;

  initial for (int c = 0; c < N; c++) edges[c] = 0;

  always @(gw) begin
    for (int c = 0; c < N; c++)
      if (gw[c] && !gprev[c]) edges[c] = edges[c] + 1;
    gprev = gw;
  end

  typedef struct {
    string name;
    int    kind;
    int    ch;
    int    exp;
  } item_t;

  item_t q[$];
  int    tests = 0;
  int    fails = 0;
  bit    done  = 1'b0;
  event  smp;

  function automatic int actual(int kind, int ch);
    case (kind)
      0: return int'(cw[ch*W +: W]);
      1: return int'(cs[ch*W +: W]);
      2: return int'(tw[ch]);
      3: return int'(ts[ch]);
      4: return int'(aw[ch]);
      default: return edges[ch];
    endcase
  endfunction

  task automatic push(string name, int kind,
                      int ch, int exp);
    item_t it;
    it.name = name;
    it.kind = kind;
    it.ch   = ch;
    it.exp  = exp;
    q.push_back(it);
  endtask

  initial begin
    item_t it;
    int    a;
    forever begin
      @(posedge clk or smp);
      #1;
      while (q.size() > 0) begin
        it = q.pop_front();
        a  = actual(it.kind, it.ch);
        tests++;
        if (a != it.exp) begin
          fails++;
          $display("FAIL %s ch%0d: got %0d, expected %0d",
                   it.name, it.ch, a, it.exp);
        end
      end
    end
  end

  initial begin
    #20000;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL timeout: stimulus did not finish");
      $display("[TB] %0d tests run, %0d failed",
               tests, fails);
      $finish;
    end
  end

  initial begin
    int ew[5];
    int es[5];
    int tcw[5];
    int tcs[5];
    int base[N];

    up_dn = 4'b0101;
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if (cw !== '0 || cs !== '0 ||
        tw !== 4'b1010 || ts !== 4'b1010) begin
      fails++;
      $display("FAIL reset state: cw=%h cs=%h tw=%b ts=%b",
               cw, cs, tw, ts);
    end
    for (int c = 0; c < N; c++) begin
      push("rst_cnt_w", 0, c, 0);
      push("rst_cnt_s", 1, c, 0);
      push("rst_tc_w", 2, c, (c % 2 == 1) ? 1 : 0);
      push("rst_tc_s", 3, c, (c % 2 == 1) ? 1 : 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) @(negedge clk);
    for (int c = 0; c < N; c++) begin
      push("idle_cnt", 0, c, 0);
      push("idle_edges", 5, c, 0);
      push("idle_act", 4, c, 0);
    end
    @(negedge clk);

    enable = 4'b0001;
    for (int k = 1; k <= 17; k++) begin
      push("up_cnt_w", 0, 0, k % 16);
      push("up_cnt_s", 1, 0, (k > 15) ? 15 : k);
      push("up_tc_w", 2, 0, (k % 16 == 15) ? 1 : 0);
      push("up_tc_s", 3, 0, (k >= 15) ? 1 : 0);
      push("up_act", 4, 0, 1);
      @(negedge clk);
    end
    enable = '0;

    load          = 4'b0010;
    load_val[7:4] = 4'd3;
    push("ld_cnt_w", 0, 1, 3);
    push("ld_cnt_s", 1, 1, 3);
    push("ld_tc_s", 3, 1, 0);
    @(negedge clk);
    load   = '0;
    enable = 4'b0010;
    ew  = '{2, 1, 0, 15, 14};
    es  = '{2, 1, 0, 0, 0};
    tcw = '{0, 0, 1, 0, 0};
    tcs = '{0, 0, 1, 1, 1};
    for (int k = 0; k < 5; k++) begin
      push("dn_cnt_w", 0, 1, ew[k]);
      push("dn_cnt_s", 1, 1, es[k]);
      push("dn_tc_w", 2, 1, tcw[k]);
      push("dn_tc_s", 3, 1, tcs[k]);
      @(negedge clk);
    end
    enable = '0;

    enable = 4'b0100;
    for (int k = 1; k <= 6; k++) begin
      push("c2_cnt_w", 0, 2, k);
      push("c2_cnt_s", 1, 2, k);
      @(negedge clk);
    end
    enable  = '0;
    base[2] = edges[2];
    for (int k = 0; k < 10; k++) begin
      push("hold_cnt", 0, 2, 6);
      push("hold_act", 4, 2, 0);
      if (k == 9) push("hold_edges", 5, 2, base[2]);
      @(negedge clk);
    end
    enable = 4'b0100;
    push("resume_cnt_w", 0, 2, 7);
    push("resume_cnt_s", 1, 2, 7);
    @(negedge clk);
    enable = '0;

    up_dn[3]        = 1'b0;
    enable          = 4'b1000;
    load            = 4'b1000;
    load_val[15:12] = 4'd9;
    push("ldpri_cnt_w", 0, 3, 9);
    push("ldpri_cnt_s", 1, 3, 9);
    push("ldpri_tc_w", 2, 3, 0);
    @(negedge clk);
    enable = '0;
    load   = '0;

    up_dn[0] = 1'b0;
    enable   = 4'b0001;
    push("dir_dn_w", 0, 0, 0);
    push("dir_dn_s", 1, 0, 14);
    push("dir_tc_w", 2, 0, 1);
    push("dir_tc_s", 3, 0, 0);
    @(negedge clk);
    up_dn[0] = 1'b1;
    push("dir_up_w", 0, 0, 1);
    push("dir_up_s", 1, 0, 15);
    push("dir_up_tc_s", 3, 0, 1);
    push("dir_up_tc_w", 2, 0, 0);
    @(negedge clk);
    enable = '0;

    scan_en = 1'b1;
    for (int c = 0; c < N; c++) base[c] = edges[c];
    for (int k = 0; k < 3; k++) begin
      push("scan_w0", 0, 0, 1);
      push("scan_s0", 1, 0, 15);
      push("scan_w1", 0, 1, 14);
      push("scan_s1", 1, 1, 0);
      push("scan_w2", 0, 2, 7);
      push("scan_w3", 0, 3, 9);
      for (int c = 0; c < N; c++) begin
        push("scan_act", 4, c, 1);
        if (k == 2)
          push("scan_edges", 5, c, base[c] + 3);
      end
      @(negedge clk);
    end
    scan_en = 1'b0;

    enable = 4'b0100;
    push("pre_rst_cnt", 0, 2, 8);
    @(negedge clk);
    push("pre_rst_cnt", 0, 2, 9);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    for (int c = 0; c < N; c++) begin
      push("async_rst_w", 0, c, 0);
      push("async_rst_s", 1, c, 0);
    end
    ->smp;
    @(negedge clk);
    rst_n = 1'b1;
    push("post_rst_w", 0, 2, 1);
    push("post_rst_s", 1, 2, 1);
    @(negedge clk);
    enable = '0;

    repeat (3) @(negedge clk);
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
